// File: rtl/irq_pending_latch_pkg.sv
// irq_pkg: shared widths, vector types and FSM states for irq_pending_latch.
// No ports; imported by the interface, the edge detector and the top.
package irq_pkg;
    localparam int N_SRC = 4;
    typedef logic [1:0]       irq_idx_t;
    typedef logic [N_SRC-1:0] irq_vec_t;
    typedef enum logic [1:0] {IDLE, PRESENT, GAP} irq_state_e;
endpackage

// File: rtl/irq_pending_latch_if.sv
// irq_pending_latch_if: groups the request, mask, encoder and consumer signals.
// slave  : the latch (takes req/mask/encoder/ready/ovf_clr, drives pend/irq/ovf).
// master : the surrounding system (encoder, consumer, request sources).
interface irq_pending_latch_if;
    import irq_pkg::*;
    irq_vec_t req_i;
    logic     mask_we_i;
    irq_vec_t mask_i;
    irq_vec_t pend_o;
    irq_idx_t enc_idx_i;
    logic     enc_valid_i;
    logic     irq_valid_o;
    irq_idx_t irq_idx_o;
    logic     irq_ready_i;
    irq_vec_t ovf_o;
    logic     ovf_clr_i;
    modport slave (
        input  req_i, mask_we_i, mask_i, enc_idx_i, enc_valid_i, irq_ready_i, ovf_clr_i,
        output pend_o, irq_valid_o, irq_idx_o, ovf_o
    );
    modport master (
        output req_i, mask_we_i, mask_i, enc_idx_i, enc_valid_i, irq_ready_i, ovf_clr_i,
        input  pend_o, irq_valid_o, irq_idx_o, ovf_o
    );
endinterface

// File: rtl/irq_pending_latch_edge_det.sv
// irq_edge_det: per-source 2-flop synchroniser plus rising-edge detector.
// Ports: clk, reset (async, active-high), req_i raw requests, event_o one-cycle
// pulse per rising edge of the synchronised request.
// Only compiled when IRQ_EDGE_DETECT_EN is defined.
`ifdef IRQ_EDGE_DETECT_EN
module irq_edge_det
    import irq_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  irq_vec_t req_i,
    output irq_vec_t event_o
);
    irq_vec_t sync1_q, sync2_q, prev_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= req_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end
    assign event_o = sync2_q & ~prev_q;
endmodule
`endif

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: sticky/maskable 4-source pending latch feeding a priority
// encoder, presenting one interrupt at a time over valid/ready.
// Ports: clk, reset (async, active-high), bus (irq_pending_latch_if.slave):
//   req_i/mask_we_i/mask_i in, pend_o to encoder, enc_idx_i/enc_valid_i back,
//   irq_valid_o/irq_idx_o/irq_ready_i consumer handshake, ovf_o/ovf_clr_i overrun.
// Macro IRQ_EDGE_DETECT_EN: defined = edge mode (sync + edge detect, sticky
// pending, overrun); undefined = level mode (pending follows req_i, ovf_o = 0).
module irq_pending_latch
    import irq_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    irq_pending_latch_if.slave  bus
);
    irq_vec_t   pending_q, pending_d, mask_q, mask_d;
    irq_state_e state_q, state_d;
    irq_idx_t   idx_q, idx_d;
`ifdef IRQ_EDGE_DETECT_EN
    irq_vec_t event_w, clr_w, ovf_q, ovf_d;
    irq_edge_det u_edge_det (
        .clk     (clk),
        .reset   (reset),
        .req_i   (bus.req_i),
        .event_o (event_w)
    );
    // Set beats clear, and overrun beats ovf_clr_i, so no event is ever lost.
    assign clr_w     = (state_q == PRESENT && bus.irq_ready_i) ? irq_vec_t'(1) << idx_q : '0;
    assign pending_d = event_w | (pending_q & ~clr_w);
    assign ovf_d     = (event_w & pending_q) | (bus.ovf_clr_i ? '0 : ovf_q);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end
    assign bus.ovf_o = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = bus.ovf_clr_i;
    assign pending_d      = bus.req_i;
    assign bus.ovf_o      = '0;
`endif
    assign mask_d = bus.mask_we_i ? bus.mask_i : mask_q;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                state_d = bus.enc_valid_i ? PRESENT : IDLE;
                idx_d   = bus.enc_valid_i ? bus.enc_idx_i : idx_q;
            end
            PRESENT: state_d = bus.irq_ready_i ? GAP : PRESENT;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '0;
            state_q   <= IDLE;
            idx_q     <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
        end
    end
    assign bus.pend_o      = pending_q & ~mask_q;
    assign bus.irq_valid_o = state_q == PRESENT;
    assign bus.irq_idx_o   = idx_q;
endmodule
